// File: rtl/divide_pkg.sv
// Shared types and constants for the divide arbiter and its divider.
package divide_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        PAD,
        RESP
    } state_t;

    typedef logic owner_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Quotient reported for a zero divisor: all ones at the given width.
    function automatic logic [MAX_WIDTH-1:0] DIV_ZERO_Q(input int unsigned width);
        return (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    endfunction

endpackage

// File: rtl/Divide.sv
// Restoring shift-subtract divider. A divisor larger than the dividend
// short-circuits to finish on the next cycle, so latency is data-dependent.
module Divide #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             finish,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int unsigned SW = $clog2(WIDTH);

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvs;
    logic [SW-1:0]    step;
    logic             active;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;

    // rem < dvs keeps the difference below 2^WIDTH, so bit WIDTH is the borrow.
    always_comb begin
        rem_sh  = {rem, quo[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, dvs};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            step   <= '0;
            active <= 1'b0;
            finish <= 1'b0;
        end else begin
            finish <= 1'b0;
            if (start) begin
                dvs  <= divisor;
                step <= '0;
                if (divisor > dividend) begin
                    quo    <= '0;
                    rem    <= dividend;
                    active <= 1'b0;
                    finish <= 1'b1;
                end else begin
                    quo    <= dividend;
                    rem    <= '0;
                    active <= 1'b1;
                end
            end else if (active) begin
                if (!rem_sub[WIDTH]) begin
                    rem <= rem_sub[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_sh[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
                step <= step + 1'b1;
                if (step == SW'(WIDTH - 1)) begin
                    active <= 1'b0;
                    finish <= 1'b1;
                end
            end
        end
    end

    assign quotient  = quo;
    assign remainder = rem;

endmodule

// File: rtl/divide_arbiter.sv
// Round-robin front end sharing one Divide between two requesters, with
// optional constant-time padding of every response.
module divide_arbiter
    import divide_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LAT = WIDTH + 2,
    parameter logic        CT_EN   = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid_0,
    input  logic             req_valid_1,
    output logic             req_ready_0,
    output logic             req_ready_1,
    input  logic [WIDTH-1:0] dividend_0,
    input  logic [WIDTH-1:0] dividend_1,
    input  logic [WIDTH-1:0] divisor_0,
    input  logic [WIDTH-1:0] divisor_1,
    output logic             rsp_valid_0,
    output logic             rsp_valid_1,
    output logic [WIDTH-1:0] quotient_0,
    output logic [WIDTH-1:0] quotient_1,
    output logic [WIDTH-1:0] remainder_0,
    output logic [WIDTH-1:0] remainder_1,
    output logic             busy,
    output logic             err
);

    localparam int unsigned      CW      = $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(MAX_LAT);
    localparam logic [CW-1:0]    CNT_TMO = CW'(MAX_LAT - 1);
    localparam logic [WIDTH-1:0] ZERO_Q  = WIDTH'(DIV_ZERO_Q(WIDTH));

    state_t           state;
    state_t           state_nx;
    owner_t           ptr;
    owner_t           grant;
    owner_t           owner;
    logic             sel_valid;
    logic             accept;
    logic             timeout;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic [CW-1:0]    cnt;
    logic             div_start;
    logic             div_finish;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;

    // cnt equals the number of cycles since the launch/bypass cycle, so the
    // timeout fires one count early to keep PAD's exit on CNT_MAX fixed.
    always_comb begin
        grant = ptr;
        if ((ptr && !req_valid_1) || (!ptr && !req_valid_0)) begin
            grant = ~ptr;
        end
        sel_valid    = grant ? req_valid_1 : req_valid_0;
        sel_dividend = grant ? dividend_1  : dividend_0;
        sel_divisor  = grant ? divisor_1   : divisor_0;
        accept       = (state == IDLE) && sel_valid;
        req_ready_0  = (state == IDLE) && !grant;
        req_ready_1  = (state == IDLE) && grant;
        timeout      = (state == WAIT) && !div_finish && (cnt == CNT_TMO);
        div_start    = (state == LAUNCH);
        busy         = (state != IDLE);
        rsp_valid_0  = (state == RESP) && !owner;
        rsp_valid_1  = (state == RESP) && owner;

        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = (sel_divisor == '0) ? PAD : LAUNCH;
            LAUNCH:  state_nx = WAIT;
            WAIT:    if (div_finish || (cnt == CNT_TMO)) state_nx = PAD;
            PAD:     if (!CT_EN || (cnt == CNT_MAX)) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            res_q       <= '0;
            res_r       <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            quotient_0  <= '0;
            remainder_0 <= '0;
            quotient_1  <= '0;
            remainder_1 <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end

            // Preload the bypass result; a launched division overwrites it.
            if (accept) begin
                owner <= grant;
                ptr   <= ~grant;
                op_a  <= sel_dividend;
                op_b  <= sel_divisor;
                res_q <= ZERO_Q;
                res_r <= sel_dividend;
            end

            if ((state == WAIT) && div_finish) begin
                res_q <= div_q;
                res_r <= div_r;
            end

            if (timeout) begin
                err   <= 1'b1;
                res_q <= '0;
                res_r <= '0;
            end

            if ((state == PAD) && (state_nx == RESP)) begin
                if (owner) begin
                    quotient_1  <= res_q;
                    remainder_1 <= res_r;
                end else begin
                    quotient_0  <= res_q;
                    remainder_0 <= res_r;
                end
            end
        end
    end

    Divide #(
        .WIDTH(WIDTH)
    ) u_divide (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (op_a),
        .divisor  (op_b),
        .finish   (div_finish),
        .quotient (div_q),
        .remainder(div_r)
    );

endmodule

// File: tb/tb_divide_arbiter.sv
// Directed and randomized checks of divide_arbiter in constant-time and
// early-response configurations against an arithmetic reference.
module tb_divide_arbiter;

    localparam int unsigned W      = 8;
    localparam int unsigned ML     = W + 2;
    localparam int unsigned CT_LAT = ML + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         rst_n;
    logic         v0, v1, rdy0, rdy1, rv0, rv1, busy, err;
    logic [W-1:0] a0, b0, a1, b1, q0, r0, q1, r1;

    logic         nv0, nv1, n_rdy0, n_rdy1, n_rv0, n_rv1, n_busy, n_err;
    logic [W-1:0] na0, nb0, na1, nb1, n_q0, n_r0, n_q1, n_r1;

    divide_arbiter #(.WIDTH(W), .MAX_LAT(ML), .CT_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(v0), .req_valid_1(v1),
        .req_ready_0(rdy0), .req_ready_1(rdy1),
        .dividend_0(a0), .dividend_1(a1),
        .divisor_0(b0), .divisor_1(b1),
        .rsp_valid_0(rv0), .rsp_valid_1(rv1),
        .quotient_0(q0), .quotient_1(q1),
        .remainder_0(r0), .remainder_1(r1),
        .busy(busy), .err(err)
    );

    divide_arbiter #(.WIDTH(W), .MAX_LAT(ML), .CT_EN(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(nv0), .req_valid_1(nv1),
        .req_ready_0(n_rdy0), .req_ready_1(n_rdy1),
        .dividend_0(na0), .dividend_1(na1),
        .divisor_0(nb0), .divisor_1(nb1),
        .rsp_valid_0(n_rv0), .rsp_valid_1(n_rv1),
        .quotient_0(n_q0), .quotient_1(n_q1),
        .remainder_0(n_r0), .remainder_1(n_r1),
        .busy(n_busy), .err(n_err)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference state: round-robin pointer, last result per port, sticky error.
    bit           mptr;
    logic [W-1:0] mq[2];
    logic [W-1:0] mr[2];
    bit           merr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit tmo,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        if (tmo) begin
            q = '0;
            r = '0;
        end else if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic rdy(input int p);
        return (p != 0) ? rdy1 : rdy0;
    endfunction
    function automatic logic rv(input int p);
        return (p != 0) ? rv1 : rv0;
    endfunction
    function automatic logic [W-1:0] qo(input int p);
        return (p != 0) ? q1 : q0;
    endfunction
    function automatic logic [W-1:0] ro(input int p);
        return (p != 0) ? r1 : r0;
    endfunction

    task automatic post(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p != 0) begin v1 = 1'b1; a1 = a; b1 = b; end
        else        begin v0 = 1'b1; a0 = a; b0 = b; end
    endtask

    task automatic model_reset();
        mptr = 1'b0;
        merr = 1'b0;
        mq[0] = '0; mr[0] = '0; mq[1] = '0; mr[1] = '0;
    endtask

    // Called at a negedge with the request posted; returns the accept cycle.
    task automatic accept_wait(input int p, output int unsigned t);
        int n = 0;
        #1;
        while (!rdy(p) && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("accept_p%0d", p), rdy(p), 1'b1);
        t = cyc;
        mptr = (p == 0);
        @(negedge clk);
        if (p != 0) v1 = 1'b0; else v0 = 1'b0;
    endtask

    // Scans from the cycle after accept until the response, then checks it.
    task automatic collect(input int p, input int unsigned t, input logic [W-1:0] a,
                           input logic [W-1:0] b, input bit tmo);
        int unsigned  rcyc = 0;
        int unsigned  starts = 0;
        int unsigned  start_bad = 0;
        bit           other = 1'b0;
        logic [W-1:0] eq, er, gq, gr;
        ref_div(a, b, tmo, eq, er);
        for (int k = 0; k < 30 && rcyc == 0; k++) begin
            #1;
            if (dut.div_start) begin
                starts++;
                if (cyc != t + 1) start_bad++;
            end
            if (rv(1 - p)) other = 1'b1;
            if (rv(p)) begin
                rcyc = cyc;
                gq = qo(p);
                gr = ro(p);
            end
            @(negedge clk);
        end
        chk($sformatf("latency_p%0d_%0d/%0d", p, a, b), rcyc - t, CT_LAT);
        chk($sformatf("quotient_p%0d_%0d/%0d", p, a, b), gq, eq);
        chk($sformatf("remainder_p%0d_%0d/%0d", p, a, b), gr, er);
        chk("start_count", starts, (b == 0) ? 0 : 1);
        chk("start_cycle", start_bad, 0);
        chk("other_port_rsp", other, 1'b0);
        chk("other_port_q", qo(1 - p), mq[1 - p]);
        chk("other_port_r", ro(1 - p), mr[1 - p]);
        mq[p] = eq;
        mr[p] = er;
        if (tmo) merr = 1'b1;
        chk("err_flag", err, merr);
        chk("idle_after_rsp", busy, 1'b0);
    endtask

    task automatic run(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned t;
        post(p, a, b);
        accept_wait(p, t);
        collect(p, t, a, b, 1'b0);
    endtask

    // Early-response instance: divider results land two cycles after finish.
    task automatic nc_run(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned  t, n = 0, fcyc = 0, rcyc = 0;
        logic [W-1:0] eq, er, gq, gr;
        ref_div(a, b, 1'b0, eq, er);
        nv0 = 1'b1; na0 = a; nb0 = b;
        #1;
        while (!n_rdy0 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("nc_accept", n_rdy0, 1'b1);
        t = cyc;
        @(negedge clk);
        nv0 = 1'b0;
        for (int k = 0; k < 30 && rcyc == 0; k++) begin
            #1;
            if (fcyc == 0 && dut_nc.div_finish && n_busy) fcyc = cyc;
            if (n_rv0) begin
                rcyc = cyc;
                gq = n_q0;
                gr = n_r0;
            end
            @(negedge clk);
        end
        if (b == 0) chk($sformatf("nc_bypass_latency_%0d", a), rcyc - t, 2);
        else        chk($sformatf("nc_latency_%0d/%0d", a, b), rcyc, fcyc + 2);
        chk($sformatf("nc_quotient_%0d/%0d", a, b), gq, eq);
        chk($sformatf("nc_remainder_%0d/%0d", a, b), gr, er);
        chk("nc_port1_q", n_q1, 8'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; nv0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  t, t0, t1;
        int           first;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        v0 = 1'b0; v1 = 1'b0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        nv0 = 1'b0; nv1 = 1'b0; na0 = '0; nb0 = '0; na1 = '0; nb1 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rsp_valid", {rv0, rv1}, 2'b00);
        chk("reset_outputs", {q0, r0, q1, r1}, 32'd0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_err", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request; port 1 stays at its reset value.
        run(0, 8'd200, 8'd7);

        // Both ports valid in the first cycle after reset.
        do_reset();
        post(0, 8'd15, 8'd4);
        post(1, 8'd9, 8'd3);
        #1;
        chk("rr_first_ready0", rdy0, 1'b1);
        chk("rr_first_ready1", rdy1, 1'b0);
        accept_wait(0, t0);
        collect(0, t0, 8'd15, 8'd4, 1'b0);
        accept_wait(1, t1);
        chk("back_to_back_accept", t1 - t0, CT_LAT + 1);
        collect(1, t1, 8'd9, 8'd3, 1'b0);

        // Next simultaneous pair follows the pointer.
        post(0, 8'd20, 8'd6);
        post(1, 8'd33, 8'd5);
        #1;
        chk("rr_second_ready0", rdy0, !mptr);
        chk("rr_second_ready1", rdy1, mptr);
        first = mptr ? 1 : 0;
        accept_wait(first, t);
        collect(first, t, (first != 0) ? 8'd33 : 8'd20, (first != 0) ? 8'd5 : 8'd6, 1'b0);
        accept_wait(1 - first, t);
        collect(1 - first, t, (first != 0) ? 8'd20 : 8'd33, (first != 0) ? 8'd6 : 8'd5, 1'b0);

        // Extreme operand pairs and divide by zero.
        run(0, 8'd255, 8'd1);
        run(1, 8'd1, 8'd255);
        run(0, 8'd77, 8'd0);
        nc_run(8'd77, 8'd0);
        nc_run(8'd200, 8'd7);
        nc_run(8'd3, 8'd200);

        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 4) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            run(int'($urandom_range(0, 1)), ra, rb);
        end
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : W'($urandom_range(1, 255));
            nc_run(ra, rb);
        end

        // Divider that never finishes: timeout, zero result, sticky error.
        force dut.div_finish = 1'b0;
        post(0, 8'd50, 8'd5);
        accept_wait(0, t);
        collect(0, t, 8'd50, 8'd5, 1'b1);
        release dut.div_finish;
        run(1, 8'd50, 8'd5);

        // Reset while the divider is busy.
        post(0, 8'd100, 8'd3);
        accept_wait(0, t);
        repeat (3) @(negedge clk);
        chk("pre_reset_err", err, 1'b1);
        rst_n = 1'b0;
        post(0, 8'd40, 8'd8);
        #1;
        chk("mid_reset_busy", busy, 1'b0);
        chk("mid_reset_rsp", {rv0, rv1}, 2'b00);
        chk("mid_reset_outputs", {q0, r0, q1, r1}, 32'd0);
        chk("mid_reset_err", err, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_reset_ready0", rdy0, 1'b1);
        accept_wait(0, t);
        collect(0, t, 8'd40, 8'd8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
